bus_round_robin_arbiter: RTL and testbench

Sequential arbiter that shares the single master→slave path of the system bus among four masters (instruction fetch, data memory, two accelerator ports). It replaces fixed-priority, combinational grant selection with a round-robin grant held for a whole transaction, from request to slave finish. A watchdog aborts transactions whose slave never finishes. Its one-hot grant drives the bus address/data/request muxes; it also returns per-master finish and error strobes.

---
 rtl/bus_round_robin_arbiter_if.sv | 39 +++
 rtl/bus_round_robin_arbiter.sv | 119 +++++++++++
 tb/tb_bus_round_robin_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_round_robin_arbiter_if.sv
// Bus arbitration interface: request/finish inputs from the masters and the
// slave, grant and per-master strobes back to the bus fabric.
interface bus_round_robin_arbiter_if;
  logic [3:0] master_read_request;
  logic [3:0] master_write_request;
  logic       slave_request_finish;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic [3:0] master_request_finish;
  logic [3:0] master_error;
  logic       bus_timeout;

  // Requester / fabric side
  modport master (
    output master_read_request,
    output master_write_request,
    output slave_request_finish,
    input  grant,
    input  grant_id,
    input  grant_valid,
    input  master_request_finish,
    input  master_error,
    input  bus_timeout
  );

  // Arbiter side
  modport slave (
    input  master_read_request,
    input  master_write_request,
    input  slave_request_finish,
    output grant,
    output grant_id,
    output grant_valid,
    output master_request_finish,
    output master_error,
    output bus_timeout
  );
endinterface

// File: rtl/bus_round_robin_arbiter.sv
// Round-robin bus arbiter: holds a one-hot grant for a whole transaction,
// releases for one cycle after finish/abandon/timeout, then re-arbitrates
// starting after the last served master.
module bus_round_robin_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  bus_round_robin_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  // Last BUSY cycle before abort; wraps harmlessly when the watchdog is off.
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          WdogEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [NUM_MASTERS-1:0] OneHot0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [1:0]             grant_id_q, grant_id_d;
  logic [1:0]             last_id_q, last_id_d;
  logic [15:0]            wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_found;
  logic [1:0]             pick_id;
  logic [1:0]             cand;
  logic                   busy;
  logic                   finish_hit;
  logic                   abandon_hit;
  logic                   timeout_hit;

  assign req = bus.master_read_request | bus.master_write_request;

  // Rotating search: first requester after last_id, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = last_id_q;
    cand       = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_id_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Termination events in BUSY, priority finish > abandon > timeout.
  always_comb begin
    busy        = (state_q == StBusy);
    finish_hit  = busy && bus.slave_request_finish;
    abandon_hit = busy && !bus.slave_request_finish && !req[grant_id_q];
    timeout_hit = busy && !bus.slave_request_finish && req[grant_id_q] &&
                  WdogEn && (wdog_q == WdogLast);
  end

  // Next-state logic for the arbitration FSM and its registered grant.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StBusy;
          grant_d    = OneHot0 << pick_id;
          grant_id_d = pick_id;
          last_id_d  = pick_id;
          wdog_d     = '0;
        end
      end
      StBusy: begin
        if (finish_hit || abandon_hit || timeout_hit) begin
          state_d = StRelease;
          grant_d = '0;
        end else if (wdog_q != 16'hFFFF) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= 2'd0;
      last_id_q  <= 2'd3;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.grant                 = grant_q;
  assign bus.grant_id              = grant_id_q;
  assign bus.grant_valid           = busy;
  assign bus.master_request_finish = grant_q & {NUM_MASTERS{finish_hit}};
  assign bus.master_error          = grant_q & {NUM_MASTERS{timeout_hit}};
  assign bus.bus_timeout           = timeout_hit;

endmodule

// File: tb/tb_bus_round_robin_arbiter.sv
// Scoreboard bench for bus_round_robin_arbiter: stimulus queues expected grant
// and strobe events with their cycle stamps; a negedge monitor checks them.
module tb_bus_round_robin_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_round_robin_arbiter_if bus_if ();

  bus_round_robin_arbiter #(
    .NUM_MASTERS   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic [1:0] id;
  } gexp_t;

  typedef struct {
    int         cyc;
    logic [3:0] fin;
    logic [3:0] err;
    logic       to;
  } sexp_t;

  gexp_t gq[$];
  sexp_t sq[$];
  gexp_t g;
  sexp_t s;
  logic  prev_gv = 1'b0;

  // Monitor: new grants and any finish/error/timeout strobe.
  always @(negedge clk) begin
    if (bus_if.grant_valid && !prev_gv) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected cyc=%0d grant=%b required no grant", cyc, bus_if.grant);
      end else begin
        g = gq.pop_front();
        if (g.cyc != cyc || bus_if.grant !== g.grant || bus_if.grant_id !== g.id) begin
          errors++;
          $display("FAIL grant cyc=%0d grant=%b id=%0d required cyc=%0d grant=%b id=%0d",
                   cyc, bus_if.grant, bus_if.grant_id, g.cyc, g.grant, g.id);
        end
      end
    end
    prev_gv = bus_if.grant_valid;
    if ((|bus_if.master_request_finish) || (|bus_if.master_error) || bus_if.bus_timeout) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected cyc=%0d fin=%b err=%b to=%b required none", cyc,
                 bus_if.master_request_finish, bus_if.master_error, bus_if.bus_timeout);
      end else begin
        s = sq.pop_front();
        if (s.cyc != cyc || bus_if.master_request_finish !== s.fin ||
            bus_if.master_error !== s.err || bus_if.bus_timeout !== s.to) begin
          errors++;
          $display("FAIL strobe cyc=%0d fin=%b err=%b to=%b required cyc=%0d fin=%b err=%b to=%b",
                   cyc, bus_if.master_request_finish, bus_if.master_error, bus_if.bus_timeout,
                   s.cyc, s.fin, s.err, s.to);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with master idx requesting and winning the search.
  // Finish arrives d cycles after the grant; drop_mask requests clear in RELEASE.
  task automatic txn(input int idx, input int d, input logic [3:0] drop_mask);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    gq.push_back('{cyc + 1, oh, 2'(idx)});
    step(1 + d);
    bus_if.slave_request_finish = 1'b1;
    sq.push_back('{cyc, oh, 4'b0000, 1'b0});
    step(1);
    bus_if.slave_request_finish = 1'b0;
    bus_if.master_read_request  = bus_if.master_read_request & ~drop_mask;
    bus_if.master_write_request = bus_if.master_write_request & ~drop_mask;
    chk("release_grant", {28'd0, bus_if.grant}, 32'd0);
    chk("release_valid", {31'd0, bus_if.grant_valid}, 32'd0);
    step(1);
    chk("idle_valid", {31'd0, bus_if.grant_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.master_read_request  = 4'b0000;
    bus_if.master_write_request = 4'b0000;
    bus_if.slave_request_finish = 1'b0;
    step(3);
    chk("rst_grant", {28'd0, bus_if.grant}, 32'd0);
    chk("rst_grant_id", {30'd0, bus_if.grant_id}, 32'd0);
    chk("rst_valid", {31'd0, bus_if.grant_valid}, 32'd0);
    chk("rst_finish", {28'd0, bus_if.master_request_finish}, 32'd0);
    chk("rst_error", {28'd0, bus_if.master_error}, 32'd0);
    chk("rst_timeout", {31'd0, bus_if.bus_timeout}, 32'd0);
    rst = 1'b0;

    // Reset pulsed mid-BUSY drops the grant at once.
    bus_if.master_read_request = 4'b0001;
    gq.push_back('{cyc + 1, 4'b0001, 2'd0});
    step(2);
    rst = 1'b1;
    #1;
    chk("midrst_grant", {28'd0, bus_if.grant}, 32'd0);
    chk("midrst_valid", {31'd0, bus_if.grant_valid}, 32'd0);
    step(1);
    rst = 1'b0;
    txn(0, 0, 4'b0001);

    // Single write master, finish 3 cycles after grant.
    bus_if.master_write_request = 4'b0100;
    txn(2, 3, 4'b0100);

    // Finish while idle is ignored.
    bus_if.slave_request_finish = 1'b1;
    step(2);
    bus_if.slave_request_finish = 1'b0;

    // Watchdog abort on master 3 in the 8th BUSY cycle.
    bus_if.master_read_request = 4'b1000;
    gq.push_back('{cyc + 1, 4'b1000, 2'd3});
    step(8);
    sq.push_back('{cyc, 4'b0000, 4'b1000, 1'b1});
    step(1);
    chk("timeout_release", {28'd0, bus_if.grant}, 32'd0);
    bus_if.master_read_request  = 4'b0011;
    bus_if.master_write_request = 4'b1100;
    step(1);

    // Round robin with all four requesting, starting after master 3.
    txn(0, 1, 4'b0000);
    txn(1, 1, 4'b0000);
    txn(2, 1, 4'b0000);
    txn(3, 1, 4'b0000);
    txn(0, 1, 4'b1111);

    // Fairness skip: last_id=1 then 0011 -> 0, and 0111 -> 2.
    bus_if.master_read_request = 4'b0010;
    txn(1, 0, 4'b0010);
    bus_if.master_read_request = 4'b0011;
    txn(0, 0, 4'b0011);
    bus_if.master_read_request = 4'b0010;
    txn(1, 0, 4'b0010);
    bus_if.master_read_request = 4'b0111;
    txn(2, 0, 4'b0111);

    // Abandon: granted master drops its request in BUSY, no strobes.
    bus_if.master_read_request = 4'b0001;
    gq.push_back('{cyc + 1, 4'b0001, 2'd0});
    step(1);
    bus_if.master_read_request = 4'b0000;
    step(1);
    chk("abandon_grant", {28'd0, bus_if.grant}, 32'd0);
    chk("abandon_valid", {31'd0, bus_if.grant_valid}, 32'd0);
    step(1);
    bus_if.master_read_request = 4'b0010;
    txn(1, 0, 4'b0010);

    // Finish collides with the timeout cycle: finish wins.
    bus_if.master_write_request = 4'b0100;
    gq.push_back('{cyc + 1, 4'b0100, 2'd2});
    step(8);
    bus_if.slave_request_finish = 1'b1;
    sq.push_back('{cyc, 4'b0100, 4'b0000, 1'b0});
    step(1);
    bus_if.slave_request_finish = 1'b0;
    bus_if.master_write_request = 4'b0000;
    step(3);

    chk("grant_queue_drained", gq.size(), 32'd0);
    chk("strobe_queue_drained", sq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
